mem_arb: RTL and testbench
==========================

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, word-address width (1024-word memory).
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, consecutive fetch denials before fetch is forced.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports if_req/if_addr  input  1/ADDR_WIDTH  instruction-fetch read request and word address.
REQ-006 SHALL have ports if_gnt/if_rvalid/if_rdata  output  1/1/32  fetch grant, read-data valid, read data.
REQ-007 SHALL have ports dm_req/dm_we/dm_be/dm_addr/dm_wdata  input  1/1/4/ADDR_WIDTH/32  data-port request, write flag, byte enables, address, write data.
REQ-008 SHALL have ports dm_gnt/dm_rvalid/dm_rdata  output  1/1/32  data-port grant, read-data valid, read data.
REQ-009 SHALL have ports mem_en/mem_we/mem_addr/mem_wdata  output  1/4/ADDR_WIDTH/32  single-port memory command.
REQ-010 SHALL have port mem_rdata  input  32  memory read data, valid one cycle after an enabled read.

Function
REQ-011 SHALL issue at most one memory access per cycle; grant is combinational from requests and registered state.
REQ-012 SHALL grant dm over if when both request, unless the starvation counter equals STARVE_LIMIT, in which case if wins.
REQ-013 Starvation counter SHALL increment when if_req is high and if_gnt is low, clear on if_gnt or when if_req is low, and saturate at STARVE_LIMIT.
REQ-014 Granted access SHALL drive mem_en=1, mem_addr from the winner, and mem_we=dm_be when dm_we is high, else 4'b0000.
REQ-015 With no request, mem_en SHALL be 0 and mem_we 0.
REQ-016 A granted read SHALL produce exactly one rvalid pulse on the owning port in the next cycle with rdata=mem_rdata; the owner is held in a registered tag (NONE/IF/DM).
REQ-017 A granted write SHALL complete on the grant cycle and SHALL NOT produce rvalid.
REQ-018 Back-to-back reads SHALL pipeline at one per cycle with no bubble, including alternating owners.
REQ-019 if_rdata/dm_rdata SHALL be 0 whenever the corresponding rvalid is low.
REQ-020 A requester SHALL hold req and request fields stable until gnt; deasserting without gnt is allowed and produces no access.

Reset
REQ-021 While rst=0 at a clock edge, owner tag SHALL become NONE and starvation counter 0; next-cycle rvalid outputs SHALL be 0.
REQ-022 During reset, all gnt, mem_en and mem_we SHALL be 0 regardless of requests.
REQ-023 A read granted in the cycle before reset asserts SHALL be discarded, with no rvalid issued.

Configuration
REQ-024 Macro MEM_ARB_STARVE_GUARD_EN SHALL compile in the starvation counter and REQ-012 override; when undefined, dm has strict priority and no counter exists.

Structure
REQ-025 Owner-tag enum (NONE, IF, DM) and the default width constants SHALL reside in shared package mips_pkg.
REQ-026 SHALL be one flat module; no sub-module is required.

Verification
REQ-027 Fetch-only: if_req=1 at addr 0x004, mem_rdata=0x2008_0005 -> if_gnt same cycle, if_rvalid=1 next cycle, if_rdata=0x2008_0005.
REQ-028 Contention: if_req and dm_req read at 0x010 together -> dm_gnt=1, if_gnt=0; dm_rvalid next cycle; if granted the cycle after dm_req drops.
REQ-029 Starvation (macro defined): dm_req held high, if_req high for 6 cycles -> if_gnt first on cycle 5 (after 4 denials); macro undefined -> if_gnt never while dm_req is high.
REQ-030 Write: dm_we=1, dm_be=4'b0011, addr 0x3FF, wdata 0xDEAD_BEEF -> mem_we=4'b0011, mem_addr=0x3FF, no dm_rvalid next cycle.
REQ-031 Pipelining: alternating IF/DM reads for 8 cycles -> 8 rvalid pulses, each on the correct port with the matching data.
REQ-032 Reset mid-read: read granted, rst=0 on the next edge -> no rvalid, counter 0, gnt 0 while reset is held.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the memory arbiter slice.
//
// Contents:
//   owner_t           - tag naming which port owns the read data returning
//                       from the memory in the current cycle.
//   DEF_ADDR_WIDTH    - default word-address width (1024-word memory).
//   DEF_STARVE_LIMIT  - default number of consecutive fetch denials tolerated.
//   DATA_WIDTH        - memory word width.
//   BE_WIDTH          - byte-enable width of one memory word.
package mips_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_DM   = 2'd2
   } owner_t;

   localparam int DEF_ADDR_WIDTH   = 10;
   localparam int DEF_STARVE_LIMIT = 4;
   localparam int DATA_WIDTH       = 32;
   localparam int BE_WIDTH         = 4;

endpackage

// File: rtl/mem_arb.sv
// Two-port arbiter in front of a single-port synchronous memory.
//
// The data port (dm) normally has priority over the instruction-fetch port
// (if). At most one access is issued per cycle. Read data comes back one
// cycle after the grant and is steered to the port recorded in a registered
// owner tag, so back-to-back reads pipeline with no bubble.
//
// Configuration macro:
//   MEM_ARB_STARVE_GUARD_EN - when defined, a counter of consecutive fetch
//                             denials lets fetch win once it reaches
//                             STARVE_LIMIT. When undefined, dm has strict
//                             priority and no counter is built.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   synchronous reset, active low
//   if_req     in   fetch read request
//   if_addr    in   fetch word address
//   if_gnt     out  fetch granted this cycle
//   if_rvalid  out  fetch read data valid
//   if_rdata   out  fetch read data (0 when if_rvalid is low)
//   dm_req     in   data-port request
//   dm_we      in   data-port write flag
//   dm_be      in   data-port byte enables
//   dm_addr    in   data-port word address
//   dm_wdata   in   data-port write data
//   dm_gnt     out  data port granted this cycle
//   dm_rvalid  out  data-port read data valid
//   dm_rdata   out  data-port read data (0 when dm_rvalid is low)
//   mem_en     out  memory access enable
//   mem_we     out  memory byte write enables (0 for reads)
//   mem_addr   out  memory word address
//   mem_wdata  out  memory write data
//   mem_rdata  in   memory read data, valid the cycle after an enabled read
module mem_arb
   import mips_pkg::*;
#(
   parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
   parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic                  if_gnt,
   output logic                  if_rvalid,
   output logic [DATA_WIDTH-1:0] if_rdata,
   input  logic                  dm_req,
   input  logic                  dm_we,
   input  logic [BE_WIDTH-1:0]   dm_be,
   input  logic [ADDR_WIDTH-1:0] dm_addr,
   input  logic [DATA_WIDTH-1:0] dm_wdata,
   output logic                  dm_gnt,
   output logic                  dm_rvalid,
   output logic [DATA_WIDTH-1:0] dm_rdata,
   output logic                  mem_en,
   output logic [BE_WIDTH-1:0]   mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   owner_t owner_q;
   owner_t owner_d;
   logic   if_win;
   logic   dm_win;

   if (STARVE_LIMIT < 1) begin : g_bad_starve_limit
      $error("mem_arb: STARVE_LIMIT must be at least 1");
   end

`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

   logic [CNT_W-1:0] starve_cnt;
   logic             force_if;

   assign force_if = (starve_cnt == CNT_W'(STARVE_LIMIT));

   // dm wins ties unless fetch has been refused STARVE_LIMIT times in a row
   always_comb begin
      dm_win = dm_req && !(if_req && force_if);
      if_win = if_req && !dm_win;
   end

   // Counts consecutive cycles fetch asked and was refused; saturates so the
   // override stays armed until fetch is actually granted or withdraws.
   always_ff @(posedge clk) begin
      if (!rst) begin
         starve_cnt <= '0;
      end else if (!if_req || if_gnt) begin
         starve_cnt <= '0;
      end else if (!force_if) begin
         starve_cnt <= starve_cnt + CNT_W'(1);
      end
   end
`else
   always_comb begin
      dm_win = dm_req;
      if_win = if_req && !dm_req;
   end
`endif

   // Grants are suppressed while reset is held, whatever the requests say
   assign if_gnt = rst && if_win;
   assign dm_gnt = rst && dm_win;

   // Memory command and next owner tag. Only reads need an owner; writes
   // complete on the grant cycle and return nothing.
   always_comb begin
      mem_en    = if_gnt || dm_gnt;
      mem_we    = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      owner_d   = OWN_NONE;
      if (dm_gnt) begin
         mem_addr  = dm_addr;
         mem_wdata = dm_wdata;
         if (dm_we) begin
            mem_we = dm_be;
         end else begin
            owner_d = OWN_DM;
         end
      end else if (if_gnt) begin
         mem_addr = if_addr;
         owner_d  = OWN_IF;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         owner_q <= OWN_NONE;
      end else begin
         owner_q <= owner_d;
      end
   end

   // Gating with rst drops a read whose grant was issued the cycle before
   // reset asserted, since the owner tag still holds it during that cycle.
   assign if_rvalid = rst && (owner_q == OWN_IF);
   assign dm_rvalid = rst && (owner_q == OWN_DM);
   assign if_rdata  = if_rvalid ? mem_rdata : '0;
   assign dm_rdata  = dm_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb.
//
// Directed vectors drive the arbiter one cycle at a time. Each vector pushes
// its hand-computed grant/command expectation, and any expected read
// response, into scoreboard queues; an independent monitor on the falling
// edge pops and compares. A small behavioural memory supplies mem_rdata.
// Starvation expectations follow MEM_ARB_STARVE_GUARD_EN.
module tb_mem_arb;

   localparam int AW = 10;

`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   localparam logic [1:0] P_NONE = 2'b00;
   localparam logic [1:0] P_IF   = 2'b10;
   localparam logic [1:0] P_DM   = 2'b01;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          if_req = 1'b0;
   logic [AW-1:0] if_addr = '0;
   logic          if_gnt;
   logic          if_rvalid;
   logic [31:0]   if_rdata;
   logic          dm_req = 1'b0;
   logic          dm_we = 1'b0;
   logic [3:0]    dm_be = '0;
   logic [AW-1:0] dm_addr = '0;
   logic [31:0]   dm_wdata = '0;
   logic          dm_gnt;
   logic          dm_rvalid;
   logic [31:0]   dm_rdata;
   logic          mem_en;
   logic [3:0]    mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata = '0;

   typedef struct {
      string         name;
      logic          if_gnt;
      logic          dm_gnt;
      logic [3:0]    mem_we;
      logic          chk_addr;
      logic [AW-1:0] mem_addr;
      logic          chk_wdata;
      logic [31:0]   mem_wdata;
   } cmd_t;

   typedef struct {
      string       name;
      logic [1:0]  port;
      logic [31:0] data;
      int          due;
   } rsp_t;

   cmd_t        cmd_q[$];
   rsp_t        rsp_q[$];
   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;
   logic [31:0] mem [0:1023];

   mem_arb #(.ADDR_WIDTH(AW), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
      .dm_rdata(dm_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural single-port memory: registered read, byte-masked write
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we == 4'b0000) begin
            mem_rdata <= mem[mem_addr];
         end else begin
            for (int b = 0; b < 4; b++) begin
               if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   // Drive one cycle of inputs and queue what the DUT must do in response
   task automatic applyStimulus(input string name, input logic r,
                                input logic ir, input logic [AW-1:0] ia,
                                input logic dr, input logic dw,
                                input logic [3:0] be, input logic [AW-1:0] da,
                                input logic [31:0] wd,
                                input logic eig, input logic edg,
                                input logic [3:0] ewe,
                                input logic [1:0] eport,
                                input logic [31:0] edata);
      cmd_t c;
      rsp_t p;
      @(posedge clk);
      #1;
      rst      = r;
      if_req   = ir;
      if_addr  = ia;
      dm_req   = dr;
      dm_we    = dw;
      dm_be    = be;
      dm_addr  = da;
      dm_wdata = wd;
      c.name      = name;
      c.if_gnt    = eig;
      c.dm_gnt    = edg;
      c.mem_we    = ewe;
      c.chk_addr  = eig | edg;
      c.mem_addr  = edg ? da : ia;
      c.chk_wdata = (ewe != 4'b0000);
      c.mem_wdata = wd;
      cmd_q.push_back(c);
      if (eport != P_NONE) begin
         p.name = name;
         p.port = eport;
         p.data = edata;
         p.due  = cyc + 1;
         rsp_q.push_back(p);
      end
   endtask

   // Monitor: compares the current cycle's command and any returning data
   always @(negedge clk) begin : monitor
      cmd_t c;
      rsp_t p;
      if (cmd_q.size() > 0) begin
         c = cmd_q.pop_front();
         checkOutput({c.name, "/if_gnt"}, 32'(if_gnt), 32'(c.if_gnt));
         checkOutput({c.name, "/dm_gnt"}, 32'(dm_gnt), 32'(c.dm_gnt));
         checkOutput({c.name, "/mem_en"}, 32'(mem_en), 32'(c.if_gnt | c.dm_gnt));
         checkOutput({c.name, "/mem_we"}, 32'(mem_we), 32'(c.mem_we));
         if (c.chk_addr)
            checkOutput({c.name, "/mem_addr"}, 32'(mem_addr), 32'(c.mem_addr));
         if (c.chk_wdata)
            checkOutput({c.name, "/mem_wdata"}, mem_wdata, c.mem_wdata);
      end
      if (if_rvalid || dm_rvalid) begin
         if (rsp_q.size() == 0) begin
            checkOutput("unexpected_rvalid", 32'({if_rvalid, dm_rvalid}), 32'h0);
         end else begin
            p = rsp_q.pop_front();
            checkOutput({p.name, "/rvalid_port"}, 32'({if_rvalid, dm_rvalid}), 32'(p.port));
            checkOutput({p.name, "/rdata"}, if_rvalid ? if_rdata : dm_rdata, p.data);
            checkOutput({p.name, "/rvalid_cycle"}, 32'(cyc), 32'(p.due));
         end
      end else if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
         p = rsp_q.pop_front();
         checkOutput({p.name, "/missing_rvalid"}, 32'h0, 32'(p.port));
      end
      if (!if_rvalid) checkOutput("if_rdata_idle", if_rdata, 32'h0);
      if (!dm_rvalid) checkOutput("dm_rdata_idle", dm_rdata, 32'h0);
   end

   initial begin : watchdog
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   initial begin : stimulus
      logic fi;
      int   waitc;
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      mem[10'h004] = 32'h2008_0005;
      mem[10'h010] = 32'h1111_0010;
      for (int i = 0; i < 8; i++) begin
         mem[32 + i] = 32'hA000_0000 + 32'(i);
         mem[64 + i] = 32'hB000_0000 + 32'(i);
      end
      $display("[TB] starting mem_arb bench (starvation guard = %0d)", GUARD);

      // Requests while in reset: nothing granted, nothing written
      repeat (2)
         applyStimulus("rst_hold", 1'b0, 1'b1, 10'h004, 1'b1, 1'b1, 4'hF, 10'h010, 32'h1234_5678,
                       1'b0, 1'b0, 4'h0, P_NONE, 32'h0);
      applyStimulus("idle", 1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 4'h0, 10'h000, 32'h0,
                    1'b0, 1'b0, 4'h0, P_NONE, 32'h0);

      // Fetch-only read
      applyStimulus("fetch", 1'b1, 1'b1, 10'h004, 1'b0, 1'b0, 4'h0, 10'h000, 32'h0,
                    1'b1, 1'b0, 4'h0, P_IF, 32'h2008_0005);
      applyStimulus("idle", 1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 4'h0, 10'h000, 32'h0,
                    1'b0, 1'b0, 4'h0, P_NONE, 32'h0);

      // Contention: dm wins, fetch follows once dm drops
      applyStimulus("contend", 1'b1, 1'b1, 10'h010, 1'b1, 1'b0, 4'h0, 10'h010, 32'h0,
                    1'b0, 1'b1, 4'h0, P_DM, 32'h1111_0010);
      applyStimulus("contend_if", 1'b1, 1'b1, 10'h010, 1'b0, 1'b0, 4'h0, 10'h000, 32'h0,
                    1'b1, 1'b0, 4'h0, P_IF, 32'h1111_0010);

      // Partial write at the top address, then read it back
      applyStimulus("write", 1'b1, 1'b0, 10'h000, 1'b1, 1'b1, 4'b0011, 10'h3FF, 32'hDEAD_BEEF,
                    1'b0, 1'b1, 4'b0011, P_NONE, 32'h0);
      applyStimulus("readback", 1'b1, 1'b0, 10'h000, 1'b1, 1'b0, 4'h0, 10'h3FF, 32'h0,
                    1'b0, 1'b1, 4'h0, P_DM, 32'h0000_BEEF);

      // Alternating IF/DM reads, one per cycle
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0)
            applyStimulus("pipe_if", 1'b1, 1'b1, 10'(32'h20 + i), 1'b0, 1'b0, 4'h0, 10'h000, 32'h0,
                          1'b1, 1'b0, 4'h0, P_IF, 32'hA000_0000 + 32'(i));
         else
            applyStimulus("pipe_dm", 1'b1, 1'b0, 10'h000, 1'b1, 1'b0, 4'h0, 10'(32'h40 + i), 32'h0,
                          1'b0, 1'b1, 4'h0, P_DM, 32'hB000_0000 + 32'(i));
      end
      applyStimulus("idle", 1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 4'h0, 10'h000, 32'h0,
                    1'b0, 1'b0, 4'h0, P_NONE, 32'h0);

      // Starvation: fetch forced on the 5th cycle only with the guard built in
      for (int k = 1; k <= 6; k++) begin
         fi = GUARD && (k == 5);
         applyStimulus("starve", 1'b1, 1'b1, 10'h004, 1'b1, 1'b0, 4'h0, 10'h010, 32'h0,
                       fi, !fi, 4'h0, fi ? P_IF : P_DM, fi ? 32'h2008_0005 : 32'h1111_0010);
      end
      applyStimulus("idle", 1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 4'h0, 10'h000, 32'h0,
                    1'b0, 1'b0, 4'h0, P_NONE, 32'h0);

      // Build up denials, reset right after a granted read: that read is dropped
      for (int k = 1; k <= 3; k++)
         applyStimulus("pre_rst", 1'b1, 1'b1, 10'h004, 1'b1, 1'b0, 4'h0, 10'h010, 32'h0,
                       1'b0, 1'b1, 4'h0, (k < 3) ? P_DM : P_NONE, 32'h1111_0010);
      repeat (2)
         applyStimulus("rst_mid", 1'b0, 1'b1, 10'h004, 1'b1, 1'b0, 4'h0, 10'h010, 32'h0,
                       1'b0, 1'b0, 4'h0, P_NONE, 32'h0);

      // Counter restarted from zero: four more denials before fetch is forced
      for (int k = 1; k <= 5; k++) begin
         fi = GUARD && (k == 5);
         applyStimulus("post_rst", 1'b1, 1'b1, 10'h004, 1'b1, 1'b0, 4'h0, 10'h010, 32'h0,
                       fi, !fi, 4'h0, fi ? P_IF : P_DM, fi ? 32'h2008_0005 : 32'h1111_0010);
      end
      repeat (2)
         applyStimulus("idle", 1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 4'h0, 10'h000, 32'h0,
                       1'b0, 1'b0, 4'h0, P_NONE, 32'h0);

      waitc = 0;
      while ((cmd_q.size() > 0 || rsp_q.size() > 0) && waitc < 20) begin
         @(posedge clk);
         waitc++;
      end
      @(posedge clk);
      #1;
      checkOutput("drain_cmd_queue", 32'(cmd_q.size()), 32'h0);
      checkOutput("drain_rsp_queue", 32'(rsp_q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
